mem_copy_engine: RTL and testbench
==================================

// Module: mem_copy_engine
// PURPOSE
//  Bus initiator for the single-port data memory: copies a block of LEN words from SRC to DST.
//  - Issues read then write cycles on the memory's we/addr/wdata/rdata interface.
//  - Started by the control unit; reports busy/done.
//  - Frees the datapath from word-by-word block moves (stack/frame copies, buffer init).
// PARAMETERS
//  DATA_W  16  memory word width, matches data-memory word width
//  ADDR_W  16  memory address width; addresses wrap modulo 2**ADDR_W
// PORTS
//  clock        in   1       clock; all state changes on posedge
//  reset        in   1       asynchronous, active-high
//  start        in   1       request a copy; sampled only in IDLE
//  src_addr     in   ADDR_W  first source address, latched on accepted start
//  dst_addr     in   ADDR_W  first destination address, latched on accepted start
//  len          in   ADDR_W  words to copy; 0 = no memory access
//  busy         out  1       high from accepted start until done
//  done         out  1       one-cycle pulse at completion (also on error abort)
//  words_done   out  ADDR_W  words written so far; holds final count after done
//  error        out  1       verify mismatch flag, sticky until next accepted start
//  mem_we       out  1       memory write enable
//  mem_addr     out  ADDR_W  memory address
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  memory read data
// BEHAVIOUR
//  Memory contract:
//  - Memory samples we/addr/wdata at posedge.
//  - mem_rdata = word at sampled addr, registered at that same edge.
//  - Read-during-write returns the old word.
//  Reset (async): state=IDLE, busy=0, done=0, error=0, words_done=0, mem_we=0, mem_addr=0, mem_wdata=0.
//  - Reset mid-copy aborts immediately; a partially written block stays as is.
//  FSM, defined without MEM_VERIFY_EN:
//  - IDLE: start=1 latches src/dst/len, clears words_done/error, sets busy.
//    - len=0 -> DONE; else -> RD.
//  - RD: mem_addr=src, mem_we=0 -> WR.
//  - WR: mem_addr=dst, mem_we=1, mem_wdata=mem_rdata.
//    - src++, dst++, words_done++.
//    - words_done+1==len -> DONE; else -> RD.
//  - DONE: done=1, busy=0 -> IDLE.
//  Timing: start accepted at edge E -> done high in the cycle after edge E+2*len (len=0: after E+1).
//  Boundaries:
//  - mem_we is 1 only in WR; outside WR, mem_addr/mem_wdata are don't-care but stable.
//  - start while busy or in DONE is ignored, never queued.
//  - src/dst wrap at 2**ADDR_W without error.
//  - Overlapping ranges copy in ascending order; overlap is not detected.
// CONFIGURATION
//  MEM_VERIFY_EN defined:
//  - WR stores the written word in vbuf and goes to VRD.
//  - VRD: mem_addr=dst-1, mem_we=0.
//  - VCHK: mem_rdata!=vbuf sets error=1 and goes to DONE (abort); else continues as WR did.
//  - 4 cycles/word; done after edge E+4*len.
//  MEM_VERIFY_EN undefined: no VRD/VCHK/vbuf; error tied to 0.
// STRUCTURE
//  Package mem_copy_pkg: state_t enum (IDLE,RD,WR,VRD,VCHK,DONE), DATA_W/ADDR_W defaults.
//  Single module; no sub-module, counters and FSM inline.
// TESTING
//  Memory model: mem[i]=i at init.
//  1. src=0x0010 dst=0x0100 len=4 -> mem[0x100..0x103]=0x0010..0x0013;
//     done 8 cycles after start; words_done=4.
//  2. len=0 -> no mem_we; done 1 cycle after start; busy for exactly that cycle.
//  3. src=0xFFFE dst=0x0020 len=3 -> mem[0x20..0x22]=0xFFFE,0xFFFF,0x0000 (address wrap).
//  4. start pulsed again at cycle 3 of a len=4 copy -> ignored; exactly 4 writes, one done pulse.
//  5. reset asserted after 2nd write of a len=6 copy -> mem_we=0 same cycle; busy=0;
//     mem[dst+2..] unchanged.
//  6. MEM_VERIFY_EN, model corrupts mem[0x101] after its write -> error=1;
//     done after 2nd word; words_done=2.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared state encoding and width defaults for mem_copy_engine.
package mem_copy_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 16;

  // VRD/VCHK are only reachable when the engine is built with MEM_VERIFY_EN.
  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    VRD,
    VCHK,
    DONE
  } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: bus initiator that copies a block of LEN words from SRC to
// DST on the single-port data memory, one read cycle then one write cycle per
// word, ascending addresses, wrapping modulo 2**ADDR_W.
// Build option MEM_VERIFY_EN: each written word is read back and compared;
// a mismatch sets the sticky error flag and aborts the copy.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_done,
  output logic              error,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] words_next;
`ifdef MEM_VERIFY_EN
  logic [DATA_W-1:0] vbuf;
`endif

  assign words_next = words_done + ADDR_W'(1);

  // The read word arrives on the same edge that opens the WR cycle, so it is
  // forwarded straight onto the bus; outside WR the write data is parked at 0.
  assign mem_wdata = mem_we ? mem_rdata : '0;

`ifndef MEM_VERIFY_EN
  assign error = 1'b0;
`endif

  // Copy sequencer: bus outputs are registered on entry to the state that
  // presents them.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_done <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
`ifdef MEM_VERIFY_EN
      vbuf       <= '0;
      error      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            src_q      <= src_addr;
            dst_q      <= dst_addr;
            len_q      <= len;
            words_done <= '0;
            busy       <= 1'b1;
`ifdef MEM_VERIFY_EN
            error      <= 1'b0;
`endif
            if (len == '0) begin
              // Zero-length copy: no bus cycle, one busy cycle in DONE first.
              state <= DONE;
            end else begin
              state    <= RD;
              mem_addr <= src_addr;
              mem_we   <= 1'b0;
            end
          end
        end

        RD: begin
          state    <= WR;
          mem_addr <= dst_q;
          mem_we   <= 1'b1;
        end

        WR: begin
          src_q      <= src_q + ADDR_W'(1);
          dst_q      <= dst_q + ADDR_W'(1);
          words_done <= words_next;
          mem_we     <= 1'b0;
`ifdef MEM_VERIFY_EN
          // Keep the word just written and read the same location back.
          vbuf     <= mem_rdata;
          state    <= VRD;
          mem_addr <= dst_q;
`else
          if (words_next == len_q) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= RD;
            mem_addr <= src_q + ADDR_W'(1);
          end
`endif
        end

`ifdef MEM_VERIFY_EN
        VRD: begin
          state <= VCHK;
        end

        VCHK: begin
          if (mem_rdata != vbuf) begin
            error <= 1'b1;
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (words_done == len_q) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= RD;
            mem_addr <= src_q;
          end
        end
`endif

        DONE: begin
          // Entered with busy still set only by a zero-length copy; that case
          // raises its done pulse one cycle later than the others.
          if (busy) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: scoreboard bench for mem_copy_engine with a behavioural
// single-port memory (mem[i]=i at init, registered read, read-old on write).
module tb_mem_copy_engine;

`ifdef MEM_VERIFY_EN
  localparam int CPW = 4;
`else
  localparam int CPW = 2;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic [15:0] words_done;
  logic        error;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:65535];
  logic        mem_init;
  logic        corrupt_en;
  logic [15:0] corrupt_addr;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  mem_copy_engine dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .error      (error),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // Memory model; optionally corrupts one address as it is written.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 16'(i);
    end else begin
      if (mem_we)
        mem[mem_addr] <= (corrupt_en && mem_addr == corrupt_addr) ? ~mem_wdata : mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  // Drive one start pulse and push the expected write stream.
  task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    wr_t e;
    @(negedge clock);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    for (int i = 0; i < int'(l); i++) begin
      e.addr = d + 16'(i);
      e.data = s + 16'(i);
      exp_q.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge (k=0); pops the
  // scoreboard on each write and records when done pulses.
  task automatic wait_copy(output int dk, output int n_wr, output int n_done,
                           output logic [63:0] bt);
    wr_t e;
    dk = -1; n_wr = 0; n_done = 0; bt = '0;
    for (int k = 0; k < 200; k++) begin
      if (k < 64) bt[k] = busy;
      if (mem_we) begin
        n_wr++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            failures++;
            $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                     mem_addr, mem_wdata, e.addr, e.data);
          end
        end
      end
      if (done) begin
        n_done++;
        if (dk < 0) dk = k;
      end
      if (dk >= 0 && k >= dk + 2) break;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    mem_init = 1'b1; corrupt_en = 1'b0; corrupt_addr = '0;
    repeat (2) @(negedge clock);
    checks += 7;
    if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (done !== 1'b0)        begin failures++; $display("FAIL reset_done: got %b required 0", done); end
    if (error !== 1'b0)       begin failures++; $display("FAIL reset_error: got %b required 0", error); end
    if (words_done !== 16'h0) begin failures++; $display("FAIL reset_words: got %h required 0", words_done); end
    if (mem_we !== 1'b0)      begin failures++; $display("FAIL reset_we: got %b required 0", mem_we); end
    if (mem_addr !== 16'h0)   begin failures++; $display("FAIL reset_addr: got %h required 0", mem_addr); end
    if (mem_wdata !== 16'h0)  begin failures++; $display("FAIL reset_wdata: got %h required 0", mem_wdata); end
    mem_init = 1'b0;
    reset    = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic;
    int dk, n_wr, n_done; logic [63:0] bt; logic [63:0] m;
    issue(16'h0010, 16'h0100, 16'd4);
    wait_copy(dk, n_wr, n_done, bt);
    m = (64'd1 << (CPW * 4 + 1)) - 1;
    checks += 6;
    if (dk !== CPW * 4)     begin failures++; $display("FAIL basic_done_cycle: got %0d required %0d", dk, CPW * 4); end
    if (n_done !== 1)       begin failures++; $display("FAIL basic_done_count: got %0d required 1", n_done); end
    if (words_done !== 16'd4) begin failures++; $display("FAIL basic_words: got %0d required 4", words_done); end
    if (error !== 1'b0)     begin failures++; $display("FAIL basic_error: got %b required 0", error); end
    if ((bt & m) !== ((64'd1 << (CPW * 4)) - 1))
      begin failures++; $display("FAIL basic_busy: got %h required %h", bt & m, (64'd1 << (CPW * 4)) - 1); end
    if (exp_q.size() != 0)  begin failures++; $display("FAIL basic_missing_writes: got %0d left required 0", exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h0100 + i] !== 16'h0010 + 16'(i)) begin
        failures++;
        $display("FAIL basic_mem[%0d]: got %h required %h", i, mem[16'h0100 + i], 16'h0010 + 16'(i));
      end
    end
  endtask

  task automatic test_len_zero;
    int dk, n_wr, n_done; logic [63:0] bt;
    issue(16'h0030, 16'h0600, 16'd0);
    wait_copy(dk, n_wr, n_done, bt);
    checks += 5;
    if (n_wr !== 0)         begin failures++; $display("FAIL len0_writes: got %0d required 0", n_wr); end
    if (dk !== 1)           begin failures++; $display("FAIL len0_done_cycle: got %0d required 1", dk); end
    if (bt[1:0] !== 2'b01)  begin failures++; $display("FAIL len0_busy: got %b required 01", bt[1:0]); end
    if (n_done !== 1)       begin failures++; $display("FAIL len0_done_count: got %0d required 1", n_done); end
    if (words_done !== 16'd0) begin failures++; $display("FAIL len0_words: got %0d required 0", words_done); end
  endtask

  task automatic test_wrap;
    int dk, n_wr, n_done; logic [63:0] bt;
    logic [15:0] want [3];
    want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000;
    issue(16'hFFFE, 16'h0020, 16'd3);
    wait_copy(dk, n_wr, n_done, bt);
    checks += 2;
    if (dk !== CPW * 3)    begin failures++; $display("FAIL wrap_done_cycle: got %0d required %0d", dk, CPW * 3); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_missing_writes: got %0d left required 0", exp_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[16'h0020 + i] !== want[i]) begin
        failures++;
        $display("FAIL wrap_mem[%0d]: got %h required %h", i, mem[16'h0020 + i], want[i]);
      end
    end
  endtask

  task automatic test_ignored_start;
    int dk, n_wr, n_done; logic [63:0] bt;
    issue(16'h0200, 16'h0300, 16'd4);
    fork
      wait_copy(dk, n_wr, n_done, bt);
      begin
        repeat (3) @(negedge clock);
        src_addr = 16'h0700; dst_addr = 16'h0780; len = 16'd2; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
    join
    checks += 4;
    if (n_wr !== 4)   begin failures++; $display("FAIL ignored_writes: got %0d required 4", n_wr); end
    if (n_done !== 1) begin failures++; $display("FAIL ignored_done_count: got %0d required 1", n_done); end
    if (dk !== CPW * 4) begin failures++; $display("FAIL ignored_done_cycle: got %0d required %0d", dk, CPW * 4); end
    if (words_done !== 16'd4) begin failures++; $display("FAIL ignored_words: got %0d required 4", words_done); end
  endtask

  task automatic test_reset_mid_copy;
    int n; wr_t e;
    issue(16'h0400, 16'h0500, 16'd6);
    n = 0;
    for (int k = 0; k < 100 && n < 2; k++) begin
      if (mem_we) begin
        n++;
        e = exp_q.pop_front();
        checks++;
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          failures++;
          $display("FAIL abort_write: addr=%h data=%h required addr=%h data=%h", mem_addr, mem_wdata, e.addr, e.data);
        end
      end
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    checks += 4;
    if (n !== 2)         begin failures++; $display("FAIL abort_seen_writes: got %0d required 2", n); end
    if (mem_we !== 1'b0) begin failures++; $display("FAIL abort_we: got %b required 0", mem_we); end
    if (busy !== 1'b0)   begin failures++; $display("FAIL abort_busy: got %b required 0", busy); end
    if (done !== 1'b0)   begin failures++; $display("FAIL abort_done: got %b required 0", done); end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      logic [15:0] want;
      want = (i < 2) ? 16'h0400 + 16'(i) : 16'h0500 + 16'(i);
      checks++;
      if (mem[16'h0500 + i] !== want) begin
        failures++;
        $display("FAIL abort_mem[%0d]: got %h required %h", i, mem[16'h0500 + i], want);
      end
    end
  endtask

`ifdef MEM_VERIFY_EN
  task automatic test_verify;
    int dk, n_wr, n_done; logic [63:0] bt;
    corrupt_en = 1'b1; corrupt_addr = 16'h0101;
    issue(16'h0010, 16'h0100, 16'd4);
    wait_copy(dk, n_wr, n_done, bt);
    corrupt_en = 1'b0;
    checks += 5;
    if (error !== 1'b1)     begin failures++; $display("FAIL verify_error: got %b required 1", error); end
    if (dk !== 8)           begin failures++; $display("FAIL verify_done_cycle: got %0d required 8", dk); end
    if (words_done !== 16'd2) begin failures++; $display("FAIL verify_words: got %0d required 2", words_done); end
    if (n_wr !== 2)         begin failures++; $display("FAIL verify_writes: got %0d required 2", n_wr); end
    if (n_done !== 1)       begin failures++; $display("FAIL verify_done_count: got %0d required 1", n_done); end
    exp_q.delete();
  endtask
`endif

  task automatic test_back_to_back;
    int dk, n_wr, n_done; logic [63:0] bt;
    issue(16'h0800, 16'hFFFF, 16'd2);
    wait_copy(dk, n_wr, n_done, bt);
    checks += 2;
    if (dk !== CPW * 2) begin failures++; $display("FAIL b2b_first_done: got %0d required %0d", dk, CPW * 2); end
    if (error !== 1'b0) begin failures++; $display("FAIL b2b_error_cleared: got %b required 0", error); end
    issue(16'h0900, 16'h0040, 16'd1);
    wait_copy(dk, n_wr, n_done, bt);
    checks += 5;
    if (dk !== CPW)         begin failures++; $display("FAIL b2b_second_done: got %0d required %0d", dk, CPW); end
    if (mem[16'hFFFF] !== 16'h0800) begin failures++; $display("FAIL b2b_mem_ffff: got %h required 0800", mem[16'hFFFF]); end
    if (mem[16'h0000] !== 16'h0801) begin failures++; $display("FAIL b2b_mem_0000: got %h required 0801", mem[16'h0000]); end
    if (mem[16'h0040] !== 16'h0900) begin failures++; $display("FAIL b2b_mem_0040: got %h required 0900", mem[16'h0040]); end
    if (exp_q.size() != 0)  begin failures++; $display("FAIL b2b_missing_writes: got %0d left required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_wrap();
    test_ignored_start();
    test_reset_mid_copy();
`ifdef MEM_VERIFY_EN
    test_verify();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
